mining_dispatcher: RTL

//  Multi-lane nonce-search controller between block_storage and an array of NCORES SHA lanes.

---
 rtl/mining_dispatcher_if.sv | 36 +++
 rtl/mining_dispatcher.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mining_dispatcher_if.sv
// Handshake bundle between block_storage, the SHA lane array, the nonce buffer
// and the mining dispatcher.
interface mining_dispatcher_if #(
   parameter int NCORES     = 4,
   parameter int NONCE_BITS = 32,
   parameter int STATE_BITS = 352
);
   logic                  blk_valid;
   logic                  blk_new;
   logic [STATE_BITS-1:0] blk_state;
   logic                  blk_ready;
   logic                  core_valid;
   logic                  core_new;
   logic [STATE_BITS-1:0] core_state;
   logic [NONCE_BITS-1:0] core_base;
   logic                  hit_valid;
   logic [NCORES-1:0]     hit_vec;
   logic                  nonce_wr;
   logic [NONCE_BITS-1:0] nonce_out;
   logic                  nonce_full;
   logic                  overflow;
   logic                  result_valid;
   logic                  success;

   modport master (
      output blk_valid, blk_new, blk_state, hit_valid, hit_vec, nonce_full,
      input  blk_ready, core_valid, core_new, core_state, core_base,
             nonce_wr, nonce_out, overflow, result_valid, success
   );

   modport slave (
      input  blk_valid, blk_new, blk_state, hit_valid, hit_vec, nonce_full,
      output blk_ready, core_valid, core_new, core_state, core_base,
             nonce_wr, nonce_out, overflow, result_valid, success
   );
endinterface

// File: rtl/mining_dispatcher.sv
// Multi-lane nonce-search controller: issues credit-limited nonce batches to
// NCORES lanes, matches in-order hit returns to issued bases, reports per block.
module mining_dispatcher #(
   parameter int NCORES     = 4,
   parameter int NONCE_BITS = 32,
   parameter int LATENCY    = 64,
   parameter int STATE_BITS = 352
) (
   input  logic                clk,
   input  logic                rst,
   mining_dispatcher_if.slave  bus
);
   localparam int PW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam int IW = $clog2(LATENCY + 1);
   localparam logic [NONCE_BITS-1:0] STEP      = NONCE_BITS'(NCORES);
   localparam logic [NONCE_BITS-1:0] LAST_BASE = ~NONCE_BITS'(NCORES - 1);
   localparam logic [PW-1:0]         PTR_MAX   = PW'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, SEARCH, FINISH, DRAIN} state_t;

   state_t                state_r;
   logic [NONCE_BITS-1:0] base_r;
   logic [IW-1:0]         in_flight_r;
   logic [PW-1:0]         wr_ptr_r;
   logic [PW-1:0]         rd_ptr_r;
   logic [NONCE_BITS-1:0] tag_mem_r [LATENCY];

   logic                  core_valid_r;
   logic                  core_new_r;
   logic [STATE_BITS-1:0] core_state_r;
   logic [NONCE_BITS-1:0] core_base_r;
   logic                  nonce_wr_r;
   logic [NONCE_BITS-1:0] nonce_out_r;
   logic                  overflow_r;
   logic                  result_valid_r;
   logic                  success_r;

   logic                  accept_s;
   logic                  pop_s;
   logic                  hit_s;
   logic                  issue_s;
   logic [NONCE_BITS-1:0] issue_base_s;

   function automatic logic [NONCE_BITS-1:0] lowest_hit(input logic [NCORES-1:0] vec);
      logic [NONCE_BITS-1:0] idx;
      idx = '0;
      for (int i = NCORES - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx = NONCE_BITS'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
      return (ptr == PTR_MAX) ? '0 : ptr + PW'(1);
   endfunction

   // Issue / pop / hit decisions for the current cycle.
   always_comb begin
      accept_s     = 1'b0;
      pop_s        = 1'b0;
      hit_s        = 1'b0;
      issue_s      = 1'b0;
      issue_base_s = base_r;
      if (state_r == IDLE) begin
         accept_s     = bus.blk_valid && bus.blk_new;
         issue_s      = accept_s;
         issue_base_s = '0;
      end else begin
         pop_s   = bus.hit_valid && (in_flight_r != '0);
         hit_s   = pop_s && (bus.hit_vec != '0) && (state_r != DRAIN);
         issue_s = (state_r == SEARCH) && (in_flight_r < IW'(LATENCY)) && !hit_s;
      end
   end

   // Controller state, tag FIFO and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r        <= IDLE;
         base_r         <= '0;
         in_flight_r    <= '0;
         wr_ptr_r       <= '0;
         rd_ptr_r       <= '0;
         core_valid_r   <= 1'b0;
         core_new_r     <= 1'b0;
         core_state_r   <= '0;
         core_base_r    <= '0;
         nonce_wr_r     <= 1'b0;
         nonce_out_r    <= '0;
         overflow_r     <= 1'b0;
         result_valid_r <= 1'b0;
         success_r      <= 1'b0;
      end else begin
         core_valid_r   <= issue_s;
         core_new_r     <= accept_s;
         nonce_wr_r     <= 1'b0;
         result_valid_r <= 1'b0;

         if (issue_s) begin
            core_base_r         <= issue_base_s;
            tag_mem_r[wr_ptr_r] <= issue_base_s;
            wr_ptr_r            <= next_ptr(wr_ptr_r);
            base_r              <= issue_base_s + STEP;
         end

         if (pop_s) begin
            rd_ptr_r <= next_ptr(rd_ptr_r);
         end

         case ({issue_s, pop_s})
            2'b10:   in_flight_r <= in_flight_r + IW'(1);
            2'b01:   in_flight_r <= in_flight_r - IW'(1);
            default: in_flight_r <= in_flight_r;
         endcase

         // A full buffer drops the winner but the block still counts as solved.
         if (hit_s) begin
            nonce_out_r <= tag_mem_r[rd_ptr_r] + lowest_hit(bus.hit_vec);
            nonce_wr_r  <= !bus.nonce_full;
            if (bus.nonce_full) begin
               overflow_r <= 1'b1;
            end
         end

         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  core_state_r <= bus.blk_state;
                  overflow_r   <= 1'b0;
                  state_r      <= SEARCH;
               end
            end
            SEARCH: begin
               if (hit_s) begin
                  state_r <= DRAIN;
               end else if (issue_s && (base_r == LAST_BASE)) begin
                  state_r <= FINISH;
               end
            end
            FINISH: begin
               if (hit_s) begin
                  state_r <= DRAIN;
               end else if (in_flight_r == '0) begin
                  result_valid_r <= 1'b1;
                  success_r      <= 1'b0;
                  state_r        <= IDLE;
               end
            end
            DRAIN: begin
               if (in_flight_r == '0) begin
                  result_valid_r <= 1'b1;
                  success_r      <= 1'b1;
                  state_r        <= IDLE;
               end
            end
            default: state_r <= IDLE;
         endcase
      end
   end

   assign bus.blk_ready    = (state_r == IDLE) && !rst;
   assign bus.core_valid   = core_valid_r;
   assign bus.core_new     = core_new_r;
   assign bus.core_state   = core_state_r;
   assign bus.core_base    = core_base_r;
   assign bus.nonce_wr     = nonce_wr_r;
   assign bus.nonce_out    = nonce_out_r;
   assign bus.overflow     = overflow_r;
   assign bus.result_valid = result_valid_r;
   assign bus.success      = success_r;
endmodule
